// File: rtl/tick_scheduler.sv
// Programmable sample-rate controller: divides clk into one-cycle sample ticks,
// counts bursts, and walks a wrapping sample address for the waveform path.
module tick_scheduler #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 16,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_cyc;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] r_tcnt;
    logic               r_tick;
    logic               r_done;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_cfg_take;
    logic [CNT_W-1:0]   w_div_in;
    logic               w_cyc_last;
    logic [BURST_W-1:0] w_tcnt_nxt;
    logic               w_burst_end;

    assign w_cfg_take  = cfg_valid && (r_state == S_IDLE);
    assign w_div_in    = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    assign w_cyc_last  = (r_cyc == r_div - CNT_W'(1));
    assign w_tcnt_nxt  = r_tcnt + BURST_W'(1);
    // Burst length 0 means continuous, so the tick counter may wrap freely.
    assign w_burst_end = (r_burst != '0) && (w_tcnt_nxt == r_burst);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= CNT_W'(1);
            r_burst <= '0;
            r_cyc   <= '0;
            r_tcnt  <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            // The address advances past each tick it was shown with.
            if (r_tick) r_addr <= r_addr + ADDR_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_take) begin
                        r_div   <= w_div_in;
                        r_burst <= cfg_burst;
                    end
                    if (start && !stop) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cyc   <= '0;
                        r_tcnt  <= '0;
                        r_addr  <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_cyc_last) begin
                        r_cyc  <= '0;
                        r_tick <= 1'b1;
                        r_tcnt <= w_tcnt_nxt;
                        if (w_burst_end) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = (r_state == S_IDLE);
    assign tick        = r_tick;
    assign done        = r_done;
    assign busy        = r_busy;
    assign sample_addr = r_addr;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random traffic, every cycle
// compared against a run-elapsed-time reference model.
module tb_tick_scheduler;
    localparam int CNT_W   = 8;
    localparam int BURST_W = 8;
    localparam int ADDR_W  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div = '0;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               tick;
    logic [ADDR_W-1:0]  sample_addr;
    logic               busy;
    logic               done;

    tick_scheduler #(.CNT_W(CNT_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
        .tick(tick), .sample_addr(sample_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is described by its divisor, burst length and the
    // number of edges since start; ticks land on multiples of the divisor.
    bit                m_run = 0;
    int                m_div = 1;
    int                m_burst = 0;
    int                m_elapsed = 0;
    int                m_ticks = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    bit                m_tick = 0;
    bit                m_done = 0;
    int                seen_ticks = 0;
    int                seen_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit prev_tick;
        prev_tick = m_tick;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_div = 1; m_burst = 0; m_elapsed = 0; m_ticks = 0; m_addr = '0;
        end else if (!m_run) begin
            if (prev_tick) m_addr = m_addr + 1'b1;
            if (cfg_valid) begin
                m_div   = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_burst = int'(cfg_burst);
            end
            if (start && !stop) begin
                m_run = 1; m_elapsed = 0; m_ticks = 0; m_addr = '0;
            end
        end else begin
            if (prev_tick) m_addr = m_addr + 1'b1;
            if (stop) begin
                m_run = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed % m_div == 0) begin
                    m_tick = 1;
                    m_ticks++;
                    if (m_burst != 0 && m_ticks == m_burst) begin
                        m_run = 0;
                        m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_run));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_run));
        chk("sample_addr", 32'(sample_addr), 32'(m_addr));
        if (tick === 1'b1) seen_ticks++;
        if (done === 1'b1) seen_done++;
    endtask

    task automatic drive(input logic cv, input int dv, input int bu, input logic st, input logic sp);
        cfg_valid = cv;
        cfg_div   = CNT_W'(dv);
        cfg_burst = BURST_W'(bu);
        start     = st;
        stop      = sp;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_addr", 32'(sample_addr), 32'd0);
        chk("reset_ready", 32'(cfg_ready), 32'd1);

        // div=4 burst=3: config, then start
        drive(1, 4, 3, 0, 0); step();
        drive(0, 0, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0; seen_done = 0;
        repeat (14) step();
        chk("burst3_ticks", 32'(seen_ticks), 32'd3);
        chk("burst3_done", 32'(seen_done), 32'd1);
        chk("burst3_busy_after", 32'(busy), 32'd0);

        // div=0 treated as 1, burst=5, config and start together
        drive(1, 0, 5, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0; seen_done = 0;
        repeat (8) step();
        chk("div0_ticks", 32'(seen_ticks), 32'd5);
        chk("div0_done", 32'(seen_done), 32'd1);

        // Continuous div=3: six ticks exercise the 2-bit address wrap
        drive(1, 3, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0; seen_done = 0;
        repeat (19) step();
        chk("cont_ticks", 32'(seen_ticks), 32'd6);
        drive(0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        repeat (4) step();
        chk("cont_done_never", 32'(seen_done), 32'd0);

        // Stop on the edge that would issue the terminal tick
        drive(1, 2, 2, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0; seen_done = 0;
        repeat (3) step();
        drive(0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        repeat (3) step();
        chk("stopterm_ticks", 32'(seen_ticks), 32'd1);
        chk("stopterm_done", 32'(seen_done), 32'd0);

        // Config writes during RUN are ignored
        drive(1, 5, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0); repeat (3) step();
        drive(1, 2, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0;
        repeat (11) step();
        chk("cfg_in_run_ticks", 32'(seen_ticks), 32'd3);
        drive(0, 0, 0, 0, 1); step();
        drive(1, 2, 0, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        seen_ticks = 0;
        repeat (6) step();
        chk("new_cfg_ticks", 32'(seen_ticks), 32'd3);
        drive(0, 0, 0, 0, 1); step();

        // Reset mid-run
        drive(1, 3, 10, 1, 0); step();
        drive(0, 0, 0, 0, 0); repeat (7) step();
        rst = 1'b1; step();
        rst = 1'b0;
        chk("midrst_tick", 32'(tick), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(sample_addr), 32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd1);
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(logic'($urandom_range(0, 3) == 0), $urandom_range(0, 6), $urandom_range(0, 5),
                  logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 15) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
